lab62soc_pio_out_pulse: RTL

Avalon-MM slave output PIO that drives a WIDTH-bit out_port from NIOS II software.
Provides a direct data register, atomic bit set/clear, and, optionally, a timed one-shot pulse generator that auto-clears bits after a programmed cycle count.
Sits on the lab62soc system interconnect alongside the input PIOs, as their write-direction counterpart (keys and switches in, LEDs and strobes out).

---
 rtl/lab62soc_pio_out_pulse_if.sv | 10 +
 rtl/lab62soc_pio_out_pulse.sv | 90 +++++++++
 2 files changed

// File: rtl/lab62soc_pio_out_pulse_if.sv
// lab62soc_pio_out_pulse_if: Avalon-MM slave bus bundle for the output PIO.
interface lab62soc_pio_out_pulse_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/lab62soc_pio_out_pulse.sv
// lab62soc_pio_out_pulse: Avalon-MM output PIO with set/clear and a timed one-shot pulse
// generator that is built only when LAB62SOC_PIO_OUT_PULSE_EN is defined.
module lab62soc_pio_out_pulse #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [15:0]     PLEN_RESET  = 16'd1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  lab62soc_pio_out_pulse_if.slave bus,
  output logic [WIDTH-1:0]        out_port,
  output logic                    pulse_busy
);
  logic             wr;
  logic [WIDTH-1:0] wd, data, data_nx;
  logic [31:0]      rd_nx;
  logic             unused_bits;
  assign wr          = bus.chipselect & ~bus.write_n;
  assign wd          = bus.writedata[WIDTH-1:0];
  assign out_port    = data;
  assign unused_bits = &{1'b0, bus.writedata};
`ifdef LAB62SOC_PIO_OUT_PULSE_EN
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t           state, state_nx;
  logic [15:0]      plen, plen_nx, cnt, cnt_nx;
  logic [WIDTH-1:0] mask, mask_nx;
  logic             expire, start;
  assign expire     = state == ACTIVE && cnt == 16'd1;
  assign start      = state == IDLE && wr && bus.address == 3'd4 && wd != '0;
  assign pulse_busy = state == ACTIVE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      plen  <= PLEN_RESET;
      cnt   <= '0;
      mask  <= '0;
    end else begin
      state <= state_nx;
      plen  <= plen_nx;
      cnt   <= cnt_nx;
      mask  <= mask_nx;
    end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mask_nx  = mask;
    plen_nx  = wr && bus.address == 3'd3 ? bus.writedata[15:0] : plen;
    if (start) begin
      state_nx = ACTIVE;
      cnt_nx   = plen == 16'd0 ? 16'd1 : plen;
      mask_nx  = wd;
    end else if (state == ACTIVE) begin
      cnt_nx = cnt - 16'd1;
      if (expire) begin
        state_nx = IDLE;
        mask_nx  = '0;
      end
    end
  end
`else
  assign pulse_busy = 1'b0;
`endif
  // auto-clear first so a same-cycle DATA/SET/CLR write overrides it
  always_comb begin
    data_nx = data;
`ifdef LAB62SOC_PIO_OUT_PULSE_EN
    if (expire) data_nx = data & ~mask;
    if (start) data_nx = data | wd;
`endif
    if (wr)
      data_nx = bus.address == 3'd0 ? wd :
                bus.address == 3'd1 ? data_nx | wd :
                bus.address == 3'd2 ? data_nx & ~wd : data_nx;
  end
  always_comb begin
    rd_nx = bus.address == 3'd0 ? 32'(data) : 32'd0;
`ifdef LAB62SOC_PIO_OUT_PULSE_EN
    if (bus.address == 3'd3) rd_nx = 32'(plen);
    if (bus.address == 3'd4) rd_nx = {31'b0, pulse_busy};
`endif
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data         <= RESET_VALUE;
      bus.readdata <= '0;
    end else begin
      data         <= data_nx;
      bus.readdata <= rd_nx;
    end
endmodule
